// File: rtl/mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mailbox_pkg
// Brief    : Shared mailbox constants, FSM state type and slot address helper.
// Revision : 1.0
// ============================================================================
package mailbox_pkg;

    localparam int MBX_SLOTS    = 16;
    localparam int MBX_ADDR_W   = 5;
    localparam int MBX_FLAG_BIT = 4;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } mbx_state_e;

    // Flag words live in the upper half of the address space.
    function automatic logic [MBX_ADDR_W-1:0] mbx_addr(input logic is_flag,
                                                       input logic [3:0] slot);
        logic [MBX_ADDR_W-1:0] a;
        a               = '0;
        a[3:0]          = slot;
        a[MBX_FLAG_BIT] = is_flag;
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mailbox_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mailbox_ctrl_if
// Brief    : Mailbox slave-port bus plus receive and post streams.
// Revision : 1.0
// ============================================================================
interface mailbox_ctrl_if;
    import mailbox_pkg::*;

    logic [MBX_ADDR_W-1:0] mbx_address;
    logic                  mbx_read;
    logic                  mbx_write;
    logic [31:0]           mbx_writedata;
    logic [31:0]           mbx_readdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_index;
    logic [31:0]           out_data;

    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_index;
    logic [31:0]           in_data;

    logic                  drop_err;

    modport master (
        output mbx_address, mbx_read, mbx_write, mbx_writedata,
        input  mbx_readdata,
        output out_valid, out_index, out_data,
        input  out_ready,
        input  in_valid, in_index, in_data,
        output in_ready, drop_err
    );

    modport slave (
        input  mbx_address, mbx_read, mbx_write, mbx_writedata,
        output mbx_readdata,
        input  out_valid, out_index, out_data,
        output out_ready,
        output in_valid, in_index, in_data,
        input  in_ready, drop_err
    );

endinterface
`default_nettype wire

// File: rtl/mailbox_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mailbox_ctrl
// Brief    : Polls inbound mailbox slots into a stream, posts outbound words.
// Revision : 1.0
// ============================================================================
module mailbox_ctrl
    import mailbox_pkg::*;
#(
    parameter int                   NUM_SLOTS = MBX_SLOTS,
    parameter logic [NUM_SLOTS-1:0] RX_MASK   = 16'h00FF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mailbox_ctrl_if.master  bus
);

    localparam logic [3:0] C_LAST_SLOT = 4'(NUM_SLOTS - 1);

    mbx_state_e            state_q, state_d;
    logic [3:0]            slot_q, slot_d;
    logic                  write_last_q, write_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            out_index_q, out_index_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  drop_err_q, drop_err_d;

    logic                  w_post;
    logic [3:0]            w_slot_next;
    logic [MBX_ADDR_W-1:0] w_addr;
    logic                  w_read;
    logic                  w_write;
    logic [31:0]           w_wdata;
    logic                  w_in_ready;

    assign w_slot_next = (slot_q == C_LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
    // HOLD leaves the port idle, so it can take a post every cycle.
    assign w_post = bus.in_valid &&
                    (((state_q == SCAN) && !write_last_q) || (state_q == HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SCAN;
            slot_q       <= '0;
            write_last_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            out_data_q   <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            write_last_q <= write_last_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            out_data_q   <= out_data_d;
            drop_err_q   <= drop_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        write_last_d = write_last_q;
        out_valid_d  = out_valid_q;
        out_index_d  = out_index_q;
        out_data_d   = out_data_q;
        drop_err_d   = 1'b0;
        w_addr       = '0;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_wdata      = '0;
        w_in_ready   = 1'b0;

        if (w_post) begin
            w_in_ready   = 1'b1;
            write_last_d = 1'b1;
            if (RX_MASK[bus.in_index]) begin
                drop_err_d = 1'b1;
            end else begin
                w_write = 1'b1;
                w_addr  = mbx_addr(1'b0, bus.in_index);
                w_wdata = bus.in_data;
            end
        end

        case (state_q)
            SCAN: begin
                if (!w_post) begin
                    w_addr       = mbx_addr(1'b1, slot_q);
                    write_last_d = 1'b0;
                    if (bus.mbx_readdata[0] && RX_MASK[slot_q]) begin
                        state_d = READ;
                    end else begin
                        slot_d = w_slot_next;
                    end
                end
            end
            READ: begin
                w_addr      = mbx_addr(1'b0, slot_q);
                w_read      = 1'b1;
                out_data_d  = bus.mbx_readdata;
                out_index_d = slot_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    slot_d      = w_slot_next;
                    state_d     = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    assign bus.mbx_address   = reset ? '0 : w_addr;
    assign bus.mbx_read      = w_read && !reset;
    assign bus.mbx_write     = w_write && !reset;
    assign bus.mbx_writedata = reset ? '0 : w_wdata;
    assign bus.in_ready      = w_in_ready && !reset;

    assign bus.out_valid     = out_valid_q;
    assign bus.out_index     = out_index_q;
    assign bus.out_data      = out_data_q;
    assign bus.drop_err      = drop_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mailbox_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mailbox_ctrl
// Brief    : Directed bench for mailbox_ctrl with a dual-port mailbox model.
// Revision : 1.0
// ============================================================================
module tb_mailbox_ctrl;
    import mailbox_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mailbox_ctrl_if bus();

    mailbox_ctrl #(.NUM_SLOTS(16), .RX_MASK(16'h00FF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Mailbox RAM: DUT on one port, CPU stimulus on the other.
    logic [31:0] mem [16];
    logic [15:0] fresh;
    logic        model_clr;
    logic        cpu_we;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata;

    assign bus.mbx_readdata = bus.mbx_address[4] ? {31'b0, fresh[bus.mbx_address[3:0]]}
                                                 : mem[bus.mbx_address[3:0]];

    always @(posedge clk) begin
        if (model_clr) begin
            fresh <= '0;
        end else begin
            if (bus.mbx_write) begin
                mem[bus.mbx_address[3:0]]   <= bus.mbx_writedata;
                fresh[bus.mbx_address[3:0]] <= 1'b1;
            end
            if (bus.mbx_read && !bus.mbx_address[4])
                fresh[bus.mbx_address[3:0]] <= 1'b0;
            if (cpu_we) begin
                mem[cpu_addr]   <= cpu_wdata;
                fresh[cpu_addr] <= 1'b1;
            end
        end
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        cyc();
        cpu_we    = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int          probe_c, read_c, valid_c, n_rd, n_v, n_stable, dl, viol;
    logic [4:0]  rd_addr;
    logic [3:0]  v_idx;
    logic [31:0] v_data;
    logic        prev_rdy, seen_read;
    bit          ok;

    initial begin
        n_chk = 0; n_pass = 0;
        reset = 1'b1; model_clr = 1'b1;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        bus.in_valid = 1'b1; bus.in_index = 4'd9; bus.in_data = 32'h55;
        bus.out_ready = 1'b0;
        cyc(); cyc();

        // Reset with a pending post
        chk("rst_read",      32'(bus.mbx_read),    0);
        chk("rst_write",     32'(bus.mbx_write),   0);
        chk("rst_in_ready",  32'(bus.in_ready),    0);
        chk("rst_out_valid", 32'(bus.out_valid),   0);
        chk("rst_out_index", 32'(bus.out_index),   0);
        chk("rst_out_data",  bus.out_data,         0);
        chk("rst_drop_err",  32'(bus.drop_err),    0);
        bus.in_valid = 1'b0; model_clr = 1'b0; reset = 1'b0;
        #1;
        chk("first_probe_addr", 32'(bus.mbx_address), 32'h10);

        // Single delivery from slot 3
        bus.out_ready = 1'b1;
        cpu_wr(4'd3, 32'hDEADBEEF);
        probe_c = -1; read_c = -1; valid_c = -1; n_rd = 0; n_v = 0;
        rd_addr = '0; v_idx = '0; v_data = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mbx_address == 5'h13 && bus.mbx_readdata[0] && probe_c < 0) probe_c = i;
            if (bus.mbx_read) begin n_rd++; rd_addr = bus.mbx_address; read_c = i; end
            if (bus.out_valid) begin n_v++; v_idx = bus.out_index; v_data = bus.out_data; valid_c = i; end
            cyc();
        end
        chk("t2_read_count",  32'(n_rd), 1);
        chk("t2_read_addr",   32'(rd_addr), 32'h03);
        chk("t2_valid_count", 32'(n_v), 1);
        chk("t2_out_index",   32'(v_idx), 3);
        chk("t2_out_data",    v_data, 32'hDEADBEEF);
        chk("t2_read_lat",    32'(read_c - probe_c), 1);
        chk("t2_valid_lat",   32'(valid_c - probe_c), 2);
        chk("t2_flag_clear",  32'(fresh[3]), 0);

        // Two fresh slots with a stalled consumer
        do_reset();
        bus.out_ready = 1'b0;
        cpu_wr(4'd3, 32'hA3A30003);
        cpu_wr(4'd5, 32'hA5A50005);
        wait_valid(40, ok);
        chk("t3_first_seen", 32'(ok), 1);
        chk("t3_first_idx",  32'(bus.out_index), 3);
        chk("t3_first_data", bus.out_data, 32'hA3A30003);
        n_stable = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.out_valid && bus.out_index == 4'd3 && bus.out_data == 32'hA3A30003) n_stable++;
        end
        chk("t3_hold_stable", 32'(n_stable), 10);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t3_valid_dropped", 32'(bus.out_valid), 0);
        wait_valid(40, ok);
        chk("t3_second_seen", 32'(ok), 1);
        chk("t3_second_idx",  32'(bus.out_index), 5);
        chk("t3_second_data", bus.out_data, 32'hA5A50005);
        reset = 1'b1;
        #1;
        chk("t3_rst_hold_valid", 32'(bus.out_valid), 0);
        cyc();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        cyc(); cyc(); cyc();

        // Post to outbound slot 9, then forced probe cycle
        bus.in_valid = 1'b1; bus.in_index = 4'd9; bus.in_data = 32'h1234;
        #1;
        chk("t4_in_ready",  32'(bus.in_ready), 1);
        chk("t4_write",     32'(bus.mbx_write), 1);
        chk("t4_addr",      32'(bus.mbx_address), 32'h09);
        chk("t4_wdata",     bus.mbx_writedata, 32'h1234);
        chk("t4_no_read",   32'(bus.mbx_read), 0);
        cyc();
        chk("t4_probe_not_ready", 32'(bus.in_ready), 0);
        chk("t4_probe_flagaddr",  32'(bus.mbx_address[4]), 1);
        chk("t4_probe_no_write",  32'(bus.mbx_write), 0);
        chk("t4_no_drop",         32'(bus.drop_err), 0);
        chk("t4_flag19",          32'(fresh[9]), 1);
        chk("t4_mem9",            mem[9], 32'h1234);
        bus.in_valid = 1'b0;
        cyc();

        // Continuous posting to slot 10 while slot 2 is fresh
        bus.in_valid = 1'b1; bus.in_index = 4'd10; bus.in_data = 32'hA5A50010;
        cpu_addr = 4'd2; cpu_wdata = 32'h22222222; cpu_we = 1'b1;
        #1;
        dl = -1; viol = 0; seen_read = 1'b0; prev_rdy = 1'b0; v_idx = '0; v_data = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid && dl < 0) begin dl = i; v_idx = bus.out_index; v_data = bus.out_data; end
            if (bus.mbx_read) seen_read = 1'b1;
            if (!seen_read && i > 0 && bus.in_ready == prev_rdy) viol++;
            prev_rdy = bus.in_ready;
            cyc();
            if (i == 0) cpu_we = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("t5_alternate",  32'(viol), 0);
        chk("t5_latency_ok", 32'(dl >= 0 && dl <= 34), 1);
        chk("t5_idx",        32'(v_idx), 2);
        chk("t5_data",       v_data, 32'h22222222);
        chk("t5_mem10",      mem[10], 32'hA5A50010);
        chk("t5_flag2_clr",  32'(fresh[2]), 0);
        cyc();

        // Post to inbound slot 4 is discarded
        cpu_wr(4'd4, 32'h44444444);
        wait_valid(40, ok);
        chk("t6_seed_seen", 32'(ok), 1);
        cyc(); cyc(); cyc();
        bus.in_valid = 1'b1; bus.in_index = 4'd4; bus.in_data = 32'hBAD0BAD0;
        #1;
        chk("t6_in_ready",   32'(bus.in_ready), 1);
        chk("t6_no_write",   32'(bus.mbx_write), 0);
        chk("t6_drop_early", 32'(bus.drop_err), 0);
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("t6_drop_pulse", 32'(bus.drop_err), 1);
        cyc();
        chk("t6_drop_clear", 32'(bus.drop_err), 0);
        chk("t6_mem4",       mem[4], 32'h44444444);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
